// File: rtl/rsr_param_pkg.sv
// Shared widths for the issue stage (also used by the issue queue and LSQ),
// plus the helper that unpacks per-lane delays.
package rsr_param_pkg;

  localparam int PHYS_LOG        = 7;
  localparam int CHECKPOINTS     = 8;
  localparam int CHECKPOINTS_LOG = 3;

  // Per-lane delays are packed 4 bits per lane, lane 0 in the low nibble.
  function automatic int lane_delay(input logic [63:0] packedDelays, input int lane);
    return {28'd0, packedDelays[lane*4 +: 4]};
  endfunction

endpackage

// File: rtl/rsr_param_if.sv
// Grant/resolve inputs and broadcast outputs of the result shift register.
import rsr_param_pkg::*;

interface rsr_param_if #(
  parameter int ISSUE_WIDTH     = 5,
  parameter int PHYS_LOG        = rsr_param_pkg::PHYS_LOG,
  parameter int CHECKPOINTS     = rsr_param_pkg::CHECKPOINTS,
  parameter int CHECKPOINTS_LOG = rsr_param_pkg::CHECKPOINTS_LOG
);
  logic                               ctrlVerified_i;
  logic                               ctrlMispredict_i;
  logic [CHECKPOINTS_LOG-1:0]         ctrlSMTid_i;
  logic [ISSUE_WIDTH-1:0]             validPacket_i;
  logic [ISSUE_WIDTH*PHYS_LOG-1:0]    grantedDest_i;
  logic [ISSUE_WIDTH*CHECKPOINTS-1:0] branchMask_i;
  logic [ISSUE_WIDTH-1:0]             rsrTagValid_o;
  logic [ISSUE_WIDTH*PHYS_LOG-1:0]    rsrTag_o;
  logic [ISSUE_WIDTH-1:0]             inflight_o;

  modport master (
    output ctrlVerified_i, ctrlMispredict_i, ctrlSMTid_i,
    output validPacket_i, grantedDest_i, branchMask_i,
    input  rsrTagValid_o, rsrTag_o, inflight_o
  );

  modport slave (
    input  ctrlVerified_i, ctrlMispredict_i, ctrlSMTid_i,
    input  validPacket_i, grantedDest_i, branchMask_i,
    output rsrTagValid_o, rsrTag_o, inflight_o
  );
endinterface

// File: rtl/rsr_param_lane.sv
// One wakeup delay line: DELAY stages of {valid, tag, mask} with branch-mask
// squash at every stage and a kill-gated broadcast from the last stage.
module rsr_lane #(
  parameter int DELAY           = 1,
  parameter int PHYS_LOG        = 7,
  parameter int CHECKPOINTS     = 8,
  parameter int CHECKPOINTS_LOG = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ctrlVerified,
  input  logic                       ctrlMispredict,
  input  logic [CHECKPOINTS_LOG-1:0] ctrlSMTid,
  input  logic                       validIn,
  input  logic [PHYS_LOG-1:0]        tagIn,
  input  logic [CHECKPOINTS-1:0]     maskIn,
  output logic                       tagValidOut,
  output logic [PHYS_LOG-1:0]        tagOut,
  output logic [DELAY-1:0]           stageValid
);

  logic                   validReg  [DELAY];
  logic [PHYS_LOG-1:0]    tagReg    [DELAY];
  logic [CHECKPOINTS-1:0] maskReg   [DELAY];
  logic                   validNext [DELAY];
  logic [PHYS_LOG-1:0]    tagNext   [DELAY];
  logic [CHECKPOINTS-1:0] maskNext  [DELAY];

  logic                   killEn;
  logic [CHECKPOINTS-1:0] clearBits;

  assign killEn    = ctrlVerified & ctrlMispredict;
  assign clearBits = (ctrlVerified & ~ctrlMispredict)
                   ? (CHECKPOINTS'(1) << ctrlSMTid) : '0;

  // Invalid stages are forced to all-zero so tag/mask never leak stale data.
  for (genvar gi = 0; gi < DELAY; gi++) begin : gStage
    if (gi == 0) begin : gCapture
      assign validNext[gi] = validIn & ~(killEn & maskIn[ctrlSMTid]);
      assign tagNext[gi]   = validNext[gi] ? tagIn : '0;
      assign maskNext[gi]  = validNext[gi] ? (maskIn & ~clearBits) : '0;
    end else begin : gShift
      assign validNext[gi] = validReg[gi-1] & ~(killEn & maskReg[gi-1][ctrlSMTid]);
      assign tagNext[gi]   = validNext[gi] ? tagReg[gi-1] : '0;
      assign maskNext[gi]  = validNext[gi] ? (maskReg[gi-1] & ~clearBits) : '0;
    end
    assign stageValid[gi] = validReg[gi];
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < DELAY; k++) begin
      if (reset) begin
        validReg[k] <= 1'b0;
        tagReg[k]   <= '0;
        maskReg[k]  <= '0;
      end else begin
        validReg[k] <= validNext[k];
        tagReg[k]   <= tagNext[k];
        maskReg[k]  <= maskNext[k];
      end
    end
  end

  // Same-cycle kill suppresses the broadcast of the output stage.
  assign tagValidOut = validReg[DELAY-1] & ~(killEn & maskReg[DELAY-1][ctrlSMTid]);
  assign tagOut      = tagValidOut ? tagReg[DELAY-1] : '0;

endmodule

// File: rtl/rsr_param.sv
// Result shift register top: per-lane slicing, delay legality check and
// inflight reduction around ISSUE_WIDTH independent delay lines.
import rsr_param_pkg::*;

module rsr_param #(
  parameter int ISSUE_WIDTH     = 5,
  parameter int PHYS_LOG        = rsr_param_pkg::PHYS_LOG,
  parameter int CHECKPOINTS     = rsr_param_pkg::CHECKPOINTS,
  parameter int CHECKPOINTS_LOG = rsr_param_pkg::CHECKPOINTS_LOG,
  parameter int MAX_DELAY       = 8,
  parameter logic [4*ISSUE_WIDTH-1:0] LANE_DELAY = 20'h13111
) (
  input logic       clk,
  input logic       reset,
  rsr_param_if.slave bus
);

  logic [ISSUE_WIDTH-1:0]          tagValidVec;
  logic [ISSUE_WIDTH*PHYS_LOG-1:0] tagVec;
  logic [ISSUE_WIDTH-1:0]          inflightVec;

  for (genvar gi = 0; gi < ISSUE_WIDTH; gi++) begin : gLane
    localparam int D = lane_delay(64'(LANE_DELAY), gi);

    if (D < 1 || D > MAX_DELAY) begin : gBadDelay
      $fatal(1, "rsr_param: lane %0d delay %0d outside 1..%0d", gi, D, MAX_DELAY);
    end else begin : gOk
      logic [D-1:0] stageValid;

      rsr_lane #(
        .DELAY          (D),
        .PHYS_LOG       (PHYS_LOG),
        .CHECKPOINTS    (CHECKPOINTS),
        .CHECKPOINTS_LOG(CHECKPOINTS_LOG)
      ) uLane (
        .clk           (clk),
        .reset         (reset),
        .ctrlVerified  (bus.ctrlVerified_i),
        .ctrlMispredict(bus.ctrlMispredict_i),
        .ctrlSMTid     (bus.ctrlSMTid_i),
        .validIn       (bus.validPacket_i[gi]),
        .tagIn         (bus.grantedDest_i[gi*PHYS_LOG +: PHYS_LOG]),
        .maskIn        (bus.branchMask_i[gi*CHECKPOINTS +: CHECKPOINTS]),
        .tagValidOut   (tagValidVec[gi]),
        .tagOut        (tagVec[gi*PHYS_LOG +: PHYS_LOG]),
        .stageValid    (stageValid)
      );

      // Ungated by the kill: a squashed entry still counts in its last cycle.
      assign inflightVec[gi] = |stageValid;
    end
  end

  assign bus.rsrTagValid_o = tagValidVec;
  assign bus.rsrTag_o      = tagVec;
  assign bus.inflight_o    = inflightVec;

endmodule

// File: tb/tb_rsr_param.sv
// Bench for rsr_param: default 5-lane build and a 2-lane (delays 1 and 8)
// build, both compared every cycle against a list-of-entries reference model.
module tb_rsr_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        ver, mis;
  logic [2:0]  sid;
  logic [4:0]  vpA;
  logic [34:0] destA;
  logic [39:0] maskA;
  logic [1:0]  vpB;
  logic [13:0] destB;
  logic [15:0] maskB;

  rsr_param_if #(.ISSUE_WIDTH(5)) ifA ();
  rsr_param_if #(.ISSUE_WIDTH(2)) ifB ();

  assign ifA.ctrlVerified_i   = ver;
  assign ifA.ctrlMispredict_i = mis;
  assign ifA.ctrlSMTid_i      = sid;
  assign ifA.validPacket_i    = vpA;
  assign ifA.grantedDest_i    = destA;
  assign ifA.branchMask_i     = maskA;
  assign ifB.ctrlVerified_i   = ver;
  assign ifB.ctrlMispredict_i = mis;
  assign ifB.ctrlSMTid_i      = sid;
  assign ifB.validPacket_i    = vpB;
  assign ifB.grantedDest_i    = destB;
  assign ifB.branchMask_i     = maskB;

  rsr_param dutA (.clk(clk), .reset(reset), .bus(ifA));
  rsr_param #(.ISSUE_WIDTH(2), .LANE_DELAY(8'h81)) dutB (.clk(clk), .reset(reset), .bus(ifB));

  // Reference model: each accepted grant is an entry due for broadcast at
  // grant cycle + lane delay, filtered by kills and updated by clears.
  typedef struct {
    int         dut;
    int         lane;
    int         tag;
    logic [7:0] mask;
    int         due;
  } ent_t;

  ent_t q[$];
  int   delA[5] = '{1, 1, 1, 3, 1};
  int   delB[2] = '{1, 8};
  int   cyc;
  int   tests = 0;
  int   fails = 0;

  function automatic bit killM(input logic [7:0] m);
    return ver && mis && m[sid];
  endfunction

  function automatic logic [7:0] clrM(input logic [7:0] m);
    return (ver && !mis) ? (m & ~(8'b1 << sid)) : m;
  endfunction

  task automatic clearInputs();
    ver = 0; mis = 0; sid = 0;
    vpA = 0; destA = 0; maskA = 0;
    vpB = 0; destB = 0; maskB = 0;
  endtask

  task automatic grantA(input int l, input int tag, input logic [7:0] m);
    vpA[l] = 1'b1;
    destA[l*7 +: 7] = 7'(tag);
    maskA[l*8 +: 8] = m;
  endtask

  task automatic grantB(input int l, input int tag, input logic [7:0] m);
    vpB[l] = 1'b1;
    destB[l*7 +: 7] = 7'(tag);
    maskB[l*8 +: 8] = m;
  endtask

  task automatic resolve(input bit mispredict, input int id);
    ver = 1'b1;
    mis = mispredict;
    sid = 3'(id);
  endtask

  task automatic checkOutputs();
    for (int d = 0; d < 2; d++) begin
      for (int l = 0; l < (d == 0 ? 5 : 2); l++) begin
        logic       expV, expI, obsV, obsI;
        logic [6:0] expT, obsT;
        expV = 0; expI = 0; expT = 0;
        foreach (q[i]) begin
          if (q[i].dut == d && q[i].lane == l) begin
            expI = 1;
            if (q[i].due == cyc && !killM(q[i].mask)) begin
              expV = 1;
              expT = 7'(q[i].tag);
            end
          end
        end
        if (d == 0) begin
          obsV = ifA.rsrTagValid_o[l];
          obsT = ifA.rsrTag_o[l*7 +: 7];
          obsI = ifA.inflight_o[l];
        end else begin
          obsV = ifB.rsrTagValid_o[l];
          obsT = ifB.rsrTag_o[l*7 +: 7];
          obsI = ifB.inflight_o[l];
        end
        tests++;
        assert (obsV === expV) else begin
          fails++;
          $error("FAIL valid dut%0d lane%0d cyc%0d: got %b expected %b", d, l, cyc, obsV, expV);
        end
        tests++;
        assert (obsT === expT) else begin
          fails++;
          $error("FAIL tag dut%0d lane%0d cyc%0d: got %h expected %h", d, l, cyc, obsT, expT);
        end
        tests++;
        assert (obsI === expI) else begin
          fails++;
          $error("FAIL inflight dut%0d lane%0d cyc%0d: got %b expected %b", d, l, cyc, obsI, expI);
        end
      end
    end
  endtask

  task automatic updateModel();
    ent_t nq[$];
    ent_t e;
    if (reset) begin
      q.delete();
      return;
    end
    foreach (q[i]) begin
      e = q[i];
      if (e.due != cyc && !killM(e.mask)) begin
        e.mask = clrM(e.mask);
        nq.push_back(e);
      end
    end
    for (int l = 0; l < 5; l++)
      if (vpA[l] && !killM(maskA[l*8 +: 8]))
        nq.push_back('{0, l, int'(destA[l*7 +: 7]), clrM(maskA[l*8 +: 8]), cyc + delA[l]});
    for (int l = 0; l < 2; l++)
      if (vpB[l] && !killM(maskB[l*8 +: 8]))
        nq.push_back('{1, l, int'(destB[l*7 +: 7]), clrM(maskB[l*8 +: 8]), cyc + delB[l]});
    q = nq;
  endtask

  // One cycle: check the settled outputs, advance the model at the edge,
  // then return with inputs back at their idle values.
  task automatic tick();
    @(negedge clk);
    checkOutputs();
    @(posedge clk);
    updateModel();
    #1;
    cyc++;
    clearInputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    clearInputs();
    reset = 1'b1;
    cyc = 0;
    @(posedge clk);
    #1;
    cyc = 1;
    idle(2);
    reset = 1'b0;
    idle(2);

    // basic latency on a delay-1 and the delay-3 lane
    grantA(0, 'h15, 8'h00);
    grantA(3, 'h22, 8'h00);
    tick();
    idle(4);

    // back-to-back on lane 3
    grantA(3, 'h01, 8'h00); tick();
    grantA(3, 'h02, 8'h00); tick();
    grantA(3, 'h03, 8'h00); tick();
    idle(4);

    // mispredict squash mid-pipe, then at the output stage
    grantA(3, 'h30, 8'h04); tick();
    tick();
    resolve(1, 2); tick();
    idle(3);
    grantA(3, 'h30, 8'h04); tick();
    idle(2);
    resolve(1, 2); tick();
    idle(2);

    // clear on id 2 protects the entry from a later mispredict on id 2
    grantA(3, 'h31, 8'h04); tick();
    resolve(0, 2); tick();
    resolve(1, 2); tick();
    idle(3);

    // kill coinciding with capture on the same checkpoint drops the grant
    grantA(0, 'h41, 8'h20);
    grantA(3, 'h42, 8'h20);
    grantA(1, 'h43, 8'h01);
    resolve(1, 5);
    tick();
    idle(4);

    // reset with lane 3 full; grant during reset is dropped
    grantA(3, 'h51, 8'h00); tick();
    grantA(3, 'h52, 8'h00); tick();
    grantA(3, 'h53, 8'h00); tick();
    reset = 1'b1;
    grantA(0, 'h54, 8'h00);
    grantB(1, 'h55, 8'h00);
    tick();
    reset = 1'b0;
    idle(4);

    // delay-8 lane of the narrow build, with a clear and a kill in flight
    grantB(1, 'h61, 8'h00); grantB(0, 'h62, 8'h00); tick();
    grantB(1, 'h63, 8'h02); tick();
    grantB(1, 'h64, 8'h08); tick();
    resolve(0, 1); tick();
    idle(2);
    resolve(1, 3); tick();
    idle(10);

    // randomized traffic on both builds
    for (int n = 0; n < 600; n++) begin
      for (int l = 0; l < 5; l++)
        if ($urandom_range(0, 99) < 45)
          grantA(l, $urandom_range(0, 127),
                 ($urandom_range(0, 2) == 0) ? 8'h00 : 8'(8'h01 << $urandom_range(0, 7)));
      for (int l = 0; l < 2; l++)
        if ($urandom_range(0, 99) < 45)
          grantB(l, $urandom_range(0, 127),
                 ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0)
        resolve($urandom_range(0, 1) == 1, $urandom_range(0, 7));
      reset = ($urandom_range(0, 149) == 0);
      tick();
      reset = 1'b0;
    end
    idle(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
